// File: rtl/ocx_tlx_rand_pkg.sv
// Shared definitions for the TLX 8-bit pseudo-random byte stream generator and checker.
package ocx_tlx_rand_pkg;

    localparam logic [7:0] RAND_SEED   = 8'h42;
    localparam logic [7:0] RAND_LOCKUP = 8'hFF;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } rand_state_e;

    // Next byte of the stream; 8'hFF maps to itself and is never produced from a legal state.
    function automatic logic [7:0] rand_next(input logic [7:0] p);
        return {p[6:0], ~(p[7] ^ p[6])};
    endfunction

endpackage

// File: rtl/ocx_tlx_rand_chk_errcnt.sv
// Saturating mismatch counter; a clear in the same cycle as an increment wins.
module ocx_tlx_rand_chk_errcnt #(
    parameter int unsigned ERR_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [ERR_W-1:0] count_o
);

    logic [ERR_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + ERR_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ocx_tlx_rand_checker.sv
// Self-synchronising checker for the TLX pseudo-random byte stream (HUNT/SYNC/LOCK).
// Define OCX_TLX_RAND_CHK_FIRST_ERR_EN to capture the first mismatch seen in LOCK.
module ocx_tlx_rand_checker
    import ocx_tlx_rand_pkg::*;
#(
    parameter int unsigned SYNC_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_cnt,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_vld,
    output logic [7:0]       first_err_exp,
    output logic [7:0]       first_err_rcv
);

    localparam int unsigned SYNC_W = $clog2(SYNC_CNT + 1);
    localparam int unsigned LOSS_W = $clog2(LOSS_CNT + 1);

    rand_state_e       state_q;
    logic [7:0]        prev_q;
    logic [SYNC_W-1:0] sync_cnt_q;
    logic [LOSS_W-1:0] loss_cnt_q;
    logic              locked_q;
    logic              err_pulse_q;

    logic [7:0]        exp_c;
    logic              match_c;
    logic              err_inc_c;
    logic [SYNC_W-1:0] sync_nxt_c;
    logic [LOSS_W-1:0] loss_nxt_c;

    assign exp_c      = rand_next(prev_q);
    assign match_c    = (data_in == exp_c);
    assign err_inc_c  = data_valid && (state_q == LOCK) && !match_c;
    assign sync_nxt_c = sync_cnt_q + SYNC_W'(1);
    assign loss_nxt_c = loss_cnt_q + LOSS_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            sync_cnt_q  <= '0;
            loss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_inc_c;
            if (data_valid) begin
                unique case (state_q)
                    HUNT: begin
                        if (data_in != RAND_LOCKUP) begin
                            prev_q     <= data_in;
                            sync_cnt_q <= '0;
                            state_q    <= SYNC;
                        end
                    end
                    SYNC: begin
                        prev_q <= data_in;
                        if (match_c) begin
                            if (sync_nxt_c == SYNC_W'(SYNC_CNT)) begin
                                sync_cnt_q <= '0;
                                loss_cnt_q <= '0;
                                locked_q   <= 1'b1;
                                state_q    <= LOCK;
                            end else begin
                                sync_cnt_q <= sync_nxt_c;
                            end
                        end else begin
                            sync_cnt_q <= '0;
                            if (data_in == RAND_LOCKUP) begin
                                state_q <= HUNT;
                            end
                        end
                    end
                    LOCK: begin
                        if (match_c) begin
                            prev_q     <= data_in;
                            loss_cnt_q <= '0;
                        end else begin
                            // Flywheel on the expected sequence so one bad byte costs one error.
                            prev_q <= exp_c;
                            if (loss_nxt_c == LOSS_W'(LOSS_CNT)) begin
                                loss_cnt_q <= '0;
                                locked_q   <= 1'b0;
                                state_q    <= HUNT;
                            end else begin
                                loss_cnt_q <= loss_nxt_c;
                            end
                        end
                    end
                    default: begin
                        locked_q <= 1'b0;
                        state_q  <= HUNT;
                    end
                endcase
            end
        end
    end

    ocx_tlx_rand_chk_errcnt #(
        .ERR_W (ERR_W)
    ) u_errcnt (
        .clock   (clock),
        .reset   (reset),
        .clear_i (clear_cnt),
        .inc_i   (err_inc_c),
        .count_o (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

`ifdef OCX_TLX_RAND_CHK_FIRST_ERR_EN
    logic       fe_vld_q;
    logic [7:0] fe_exp_q;
    logic [7:0] fe_rcv_q;

    // Holds the first LOCK mismatch until clear_cnt or reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fe_vld_q <= 1'b0;
            fe_exp_q <= '0;
            fe_rcv_q <= '0;
        end else if (clear_cnt) begin
            fe_vld_q <= 1'b0;
            fe_exp_q <= '0;
            fe_rcv_q <= '0;
        end else if (err_inc_c && !fe_vld_q) begin
            fe_vld_q <= 1'b1;
            fe_exp_q <= exp_c;
            fe_rcv_q <= data_in;
        end
    end

    assign first_err_vld = fe_vld_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_rcv = fe_rcv_q;
`else
    assign first_err_vld = 1'b0;
    assign first_err_exp = 8'h00;
    assign first_err_rcv = 8'h00;
`endif

endmodule

// File: tb/tb_ocx_tlx_rand_checker.sv
// Directed bench for ocx_tlx_rand_checker: default DUT plus an ERR_W=4 copy sharing stimulus.
module tb_ocx_tlx_rand_checker;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       vld;
    logic [7:0] din;

    logic        locked_m, pulse_m, fev_m;
    logic [15:0] cnt_m;
    logic [7:0]  fee_m, fer_m;
    logic        locked_s, pulse_s, fev_s;
    logic [3:0]  cnt_s;
    logic [7:0]  fee_s, fer_s;

    int total = 0;
    int bad   = 0;

    ocx_tlx_rand_checker dut_m (
        .clock(clk), .reset(rst), .clear_cnt(clr), .data_valid(vld), .data_in(din),
        .locked(locked_m), .err_pulse(pulse_m), .err_count(cnt_m),
        .first_err_vld(fev_m), .first_err_exp(fee_m), .first_err_rcv(fer_m)
    );

    ocx_tlx_rand_checker #(.ERR_W(4)) dut_s (
        .clock(clk), .reset(rst), .clear_cnt(clr), .data_valid(vld), .data_in(din),
        .locked(locked_s), .err_pulse(pulse_s), .err_count(cnt_s),
        .first_err_vld(fev_s), .first_err_exp(fee_s), .first_err_rcv(fer_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       vld;
        logic       clr;
        logic [7:0] d;
        logic       lk;
        logic       pu;
        int         cnt;
        logic       fv;
        logic [7:0] fe;
        logic [7:0] fr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic v, logic c, logic [7:0] d, logic lk, logic pu,
                                int cnt, logic fv, logic [7:0] fe, logic [7:0] fr);
        vec_t r;
        r.nm = nm; r.vld = v; r.clr = c; r.d = d; r.lk = lk; r.pu = pu;
        r.cnt = cnt; r.fv = fv; r.fe = fe; r.fr = fr;
        return r;
    endfunction

    function automatic logic [7:0] nx(input logic [7:0] p);
        return {p[6:0], ~(p[7] ^ p[6])};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic lk, input logic pu, input int cnt,
                           input logic fv, input logic [7:0] fe, input logic [7:0] fr);
        int cs;
        cs = (cnt > 15) ? 15 : cnt;
        chk({nm, ".locked"}, 32'(locked_m), 32'(lk));
        chk({nm, ".pulse"},  32'(pulse_m),  32'(pu));
        chk({nm, ".count"},  32'(cnt_m),    32'(cnt));
        chk({nm, ".count4"}, 32'(cnt_s),    32'(cs));
        chk({nm, ".locked4"}, 32'(locked_s), 32'(lk));
`ifdef OCX_TLX_RAND_CHK_FIRST_ERR_EN
        chk({nm, ".fe_vld"}, 32'(fev_m), 32'(fv));
        chk({nm, ".fe_exp"}, 32'(fee_m), 32'(fe));
        chk({nm, ".fe_rcv"}, 32'(fer_m), 32'(fr));
`else
        chk({nm, ".fe_vld"}, 32'(fev_m), 32'(1'b0));
        chk({nm, ".fe_exp"}, 32'(fee_m), 32'(8'h00));
        chk({nm, ".fe_rcv"}, 32'(fer_m), 32'(8'h00));
        if (fv !== fv) chk({nm, ".fe_x"}, 32'(fe), 32'(fr));
`endif
    endtask

    task automatic drive(input logic v, input logic c, input logic [7:0] d);
        @(negedge clk);
        vld = v; clr = c; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prev_m;
        logic [7:0] b;
        logic [7:0] fe_e;
        logic [7:0] fe_r;
        int         cnt;

        rst = 1'b1; clr = 1'b0; vld = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Seeded lock, single corruption, loss of lock, relock, clear, FF in HUNT.
        vecs.push_back(mk("t1_42", 1, 0, 8'h42, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk("t1_84", 1, 0, 8'h84, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk("t1_08", 1, 0, 8'h08, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk("t1_11", 1, 0, 8'h11, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk("t1_23", 1, 0, 8'h23, 1, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk("t2_46", 1, 0, 8'h46, 1, 1, 1, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t2_8e", 1, 0, 8'h8E, 1, 0, 1, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t2_1c", 1, 0, 8'h1C, 1, 0, 1, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t2_idle", 0, 0, 8'hFF, 1, 0, 1, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_e1", 1, 0, 8'h00, 1, 1, 2, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_e2", 1, 0, 8'h00, 1, 1, 3, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_e3", 1, 0, 8'h00, 0, 1, 4, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_39", 1, 0, 8'h39, 0, 0, 4, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_73", 1, 0, 8'h73, 0, 0, 4, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_e6", 1, 0, 8'hE6, 0, 0, 4, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_cd", 1, 0, 8'hCD, 0, 0, 4, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_9b", 1, 0, 8'h9B, 1, 0, 4, 1, 8'h47, 8'h46));
        vecs.push_back(mk("t3_clr", 0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk("t4_e1", 1, 0, 8'h00, 1, 1, 1, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_e2", 1, 0, 8'h00, 1, 1, 2, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_e3", 1, 0, 8'h00, 0, 1, 3, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_ff1", 1, 0, 8'hFF, 0, 0, 3, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_ff2", 1, 0, 8'hFF, 0, 0, 3, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_42", 1, 0, 8'h42, 0, 0, 3, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_84", 1, 0, 8'h84, 0, 0, 3, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_08", 1, 0, 8'h08, 0, 0, 3, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_11", 1, 0, 8'h11, 0, 0, 3, 1, 8'h36, 8'h00));
        vecs.push_back(mk("t4_23", 1, 0, 8'h23, 1, 0, 3, 1, 8'h36, 8'h00));

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].clr, vecs[i].d);
            chk_all(vecs[i].nm, vecs[i].lk, vecs[i].pu, vecs[i].cnt,
                    vecs[i].fv, vecs[i].fe, vecs[i].fr);
        end

        // Alternate corrupt/good bytes: 20 errors while staying locked; 4-bit copy saturates.
        prev_m = 8'h23;
        cnt    = 3;
        fe_e   = 8'h36;
        fe_r   = 8'h00;
        for (int i = 0; i < 20; i++) begin
            b = nx(prev_m) ^ 8'h80;
            prev_m = nx(prev_m);
            cnt++;
            drive(1'b1, 1'b0, b);
            chk_all($sformatf("t5_err%0d", i), 1'b1, 1'b1, cnt, 1'b1, fe_e, fe_r);
            prev_m = nx(prev_m);
            drive(1'b1, 1'b0, prev_m);
            chk_all($sformatf("t5_good%0d", i), 1'b1, 1'b0, cnt, 1'b1, fe_e, fe_r);
        end

        // Clear coincident with an error: clear wins on both counters and the capture.
        b = nx(prev_m) ^ 8'h01;
        prev_m = nx(prev_m);
        drive(1'b1, 1'b1, b);
        chk_all("t5_clr_err", 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00);
        prev_m = nx(prev_m);
        drive(1'b1, 1'b0, prev_m);
        chk_all("t5_good_after", 1'b1, 1'b0, 0, 1'b0, 8'h00, 8'h00);
        fe_e = nx(prev_m);
        fe_r = fe_e ^ 8'h10;
        prev_m = fe_e;
        drive(1'b1, 1'b0, fe_r);
        chk_all("t5_err_after", 1'b1, 1'b1, 1, 1'b1, fe_e, fe_r);
        b = nx(prev_m) ^ 8'h02;
        prev_m = nx(prev_m);
        drive(1'b1, 1'b0, b);
        chk_all("t5_err_keep", 1'b1, 1'b1, 2, 1'b1, fe_e, fe_r);

        // Async reset between edges drops lock and counts immediately.
        @(negedge clk);
        vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_locked", 32'(locked_m), 32'd0);
        chk("t6_count",  32'(cnt_m),    32'd0);
        chk("t6_count4", 32'(cnt_s),    32'd0);
        chk("t6_pulse",  32'(pulse_m),  32'd0);
        chk("t6_fe_vld", 32'(fev_m),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, nx(prev_m));
        chk_all("t6_after", 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
